// File: rtl/score_display_if.sv
// Bus between the game core / VGA timing and the score renderer.
// The master drives score, game events and beam coordinates; the slave returns pixel and high-score state.
interface score_display_if;
    logic [15:0] score;
    logic        game_tick;
    logic        game_start;
    logic        game_frozen;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        pixel_on;
    logic [15:0] hiscore;
    logic        new_record;

    modport master (
        output score, game_tick, game_start, game_frozen, hpos, vpos,
        input  pixel_on, hiscore, new_record
    );

    modport slave (
        input  score, game_tick, game_start, game_frozen, hpos, vpos,
        output pixel_on, hiscore, new_record
    );
endinterface

// File: rtl/score_display.sv
// Renders the frame-latched score and the session high score as 3x5 BCD digits
// scaled 4x, with leading-zero suppression and record blinking while frozen.
module score_display #(
    parameter logic [9:0] X0 = 10'd544,
    parameter logic [9:0] Y0 = 10'd16
) (
    input  logic            clk,
    input  logic            rst_n,
    score_display_if.slave  bus
);
    logic [15:0] shown_q;
    logic [15:0] hiscore_q;
    logic [4:0]  blink_q;
    logic        rec_q;
    logic        frz_q;
    logic        new_record_q;
    logic        pixel_q;

    logic        s1_box_q;
    logic        s1_hi_q;
    logic [1:0]  s1_slot_q;
    logic [1:0]  s1_col_q;
    logic [2:0]  s1_row_q;

    // Stage 1: beam position to slot / font cell coordinates.
    logic [9:0]  dx_d;
    logic [9:0]  dy_s_d;
    logic [9:0]  dy_h_d;
    logic        in_x_d;
    logic        in_s_d;
    logic        in_h_d;
    logic        box_d;
    logic [2:0]  row_d;

    assign dx_d   = bus.hpos - X0;
    assign dy_s_d = bus.vpos - Y0;
    assign dy_h_d = bus.vpos - (Y0 + 10'd24);
    // Out-of-range coordinates wrap to large unsigned values and fail the compares.
    assign in_x_d = (dx_d < 10'd64) && (dx_d[3:0] < 4'd12);
    assign in_s_d = (dy_s_d < 10'd20);
    assign in_h_d = (dy_h_d < 10'd20);
    assign box_d  = in_x_d & (in_s_d | in_h_d);
    assign row_d  = in_h_d ? dy_h_d[4:2] : dy_s_d[4:2];

    // Stage 2: digit select, leading-zero suppression and font lookup.
    logic [15:0] disp_val_d;
    logic [3:0]  dig_d [4];
    logic [3:0]  lz_d;
    logic [2:0]  font_bits_d;
    logic        font_bit_d;
    logic        blank_all_d;
    logic        pixel_d;
    logic        go_edge_d;

    assign disp_val_d = s1_hi_q ? hiscore_q : shown_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dig
            assign dig_d[gi] = disp_val_d[15 - 4*gi -: 4];
            if (gi < 3) begin : g_lz
                assign lz_d[gi] = (disp_val_d[15 -: 4*(gi+1)] == '0);
            end else begin : g_units
                assign lz_d[gi] = 1'b0;
            end
        end
    endgenerate

    function automatic logic [2:0] font_row(input logic [3:0] d, input logic [2:0] r);
        logic [14:0] g;
        logic [2:0]  bits;
        case (d)
            4'd0:    g = {3'd7, 3'd5, 3'd5, 3'd5, 3'd7};
            4'd1:    g = {3'd2, 3'd6, 3'd2, 3'd2, 3'd7};
            4'd2:    g = {3'd7, 3'd1, 3'd7, 3'd4, 3'd7};
            4'd3:    g = {3'd7, 3'd1, 3'd7, 3'd1, 3'd7};
            4'd4:    g = {3'd5, 3'd5, 3'd7, 3'd1, 3'd1};
            4'd5:    g = {3'd7, 3'd4, 3'd7, 3'd1, 3'd7};
            4'd6:    g = {3'd7, 3'd4, 3'd7, 3'd5, 3'd7};
            4'd7:    g = {3'd7, 3'd1, 3'd1, 3'd1, 3'd1};
            4'd8:    g = {3'd7, 3'd5, 3'd7, 3'd5, 3'd7};
            4'd9:    g = {3'd7, 3'd5, 3'd7, 3'd1, 3'd7};
            default: g = 15'd0;
        endcase
        case (r)
            3'd0:    bits = g[14:12];
            3'd1:    bits = g[11:9];
            3'd2:    bits = g[8:6];
            3'd3:    bits = g[5:3];
            default: bits = g[2:0];
        endcase
        return bits;
    endfunction

    assign font_bits_d = font_row(dig_d[s1_slot_q], s1_row_q);

    always_comb begin
        font_bit_d = 1'b0;
        case (s1_col_q)
            2'd0:    font_bit_d = font_bits_d[2];
            2'd1:    font_bit_d = font_bits_d[1];
            default: font_bit_d = font_bits_d[0];
        endcase
    end

    assign blank_all_d = bus.game_frozen & rec_q & blink_q[4];
    assign pixel_d     = s1_box_q & ~lz_d[s1_slot_q] & font_bit_d & ~blank_all_d;
    assign go_edge_d   = bus.game_frozen & ~frz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_q      <= '0;
            hiscore_q    <= '0;
            blink_q      <= '0;
            rec_q        <= 1'b0;
            frz_q        <= 1'b0;
            new_record_q <= 1'b0;
            pixel_q      <= 1'b0;
            s1_box_q     <= 1'b0;
            s1_hi_q      <= 1'b0;
            s1_slot_q    <= '0;
            s1_col_q     <= '0;
            s1_row_q     <= '0;
        end else begin
            frz_q        <= bus.game_frozen;
            new_record_q <= 1'b0;

            if (bus.game_start) begin
                shown_q <= '0;
            end else if (bus.game_tick) begin
                shown_q <= bus.score;
            end

            if (bus.game_tick) begin
                blink_q <= blink_q + 5'd1;
            end

            // A new game suppresses any record detection in the same cycle.
            if (bus.game_start) begin
                rec_q <= 1'b0;
            end else if (go_edge_d && (bus.score > hiscore_q)) begin
                hiscore_q    <= bus.score;
                new_record_q <= 1'b1;
                rec_q        <= 1'b1;
            end

            s1_box_q  <= box_d;
            s1_hi_q   <= in_h_d;
            s1_slot_q <= dx_d[5:4];
            s1_col_q  <= dx_d[3:2];
            s1_row_q  <= row_d;
            pixel_q   <= pixel_d;
        end
    end

    assign bus.pixel_on   = pixel_q;
    assign bus.hiscore    = hiscore_q;
    assign bus.new_record = new_record_q;
endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: stimulus pushes expected outputs tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_score_display;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    score_display_if bus();

    score_display #(.X0(10'd544), .Y0(10'd16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int kind;   // 0 pixel_on, 1 hiscore, 2 new_record
        int expv;
        int x;
        int y;
    } exp_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_shown  = '0;
    logic [15:0] m_hi     = '0;
    bit          m_rec    = 1'b0;
    int          m_blink  = 0;
    bit          m_frozen = 1'b0;

    function automatic string kname(int k);
        if (k == 0) return "pixel_on";
        if (k == 1) return "hiscore";
        return "new_record";
    endfunction

    // Monitor: compare every entry whose due cycle has arrived.
    always @(negedge clk) begin
        int i;
        int act;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due <= cyc) begin
                act = (sbq[i].kind == 0) ? int'(bus.pixel_on) :
                      (sbq[i].kind == 1) ? int'(bus.hiscore) : int'(bus.new_record);
                n_checks++;
                if (sbq[i].due < cyc) begin
                    n_fail++;
                    $display("FAIL stale %s due=%0d now=%0d", kname(sbq[i].kind), sbq[i].due, cyc);
                end else if (act != sbq[i].expv) begin
                    n_fail++;
                    $display("FAIL %s at (%0d,%0d) cyc=%0d: got %0h expected %0h",
                             kname(sbq[i].kind), sbq[i].x, sbq[i].y, cyc, act, sbq[i].expv);
                end
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push(int due, int kind, int expv, int x, int y);
        exp_t e;
        e.due = due; e.kind = kind; e.expv = expv; e.x = x; e.y = y;
        sbq.push_back(e);
    endtask

    task automatic check_now(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic bit tb_font(int d, int r, int c);
        int rows[5];
        case (d)
            0: rows = '{7,5,5,5,7};
            1: rows = '{2,6,2,2,7};
            2: rows = '{7,1,7,4,7};
            3: rows = '{7,1,7,1,7};
            4: rows = '{5,5,7,1,1};
            5: rows = '{7,4,7,1,7};
            6: rows = '{7,4,7,5,7};
            7: rows = '{7,1,1,1,1};
            8: rows = '{7,5,7,5,7};
            default: rows = '{7,5,7,1,7};
        endcase
        return bit'((rows[r] >> (2 - c)) & 1);
    endfunction

    // Reference pixel model written from geometry with division, not bit slicing.
    function automatic int exp_pix(int x, int y);
        int val, ry, k, off, d;
        if (m_frozen && m_rec && ((m_blink / 16) % 2 == 1)) return 0;
        if (y >= 16 && y < 36) begin
            val = int'(m_shown); ry = y - 16;
        end else if (y >= 40 && y < 60) begin
            val = int'(m_hi); ry = y - 40;
        end else return 0;
        if (x < 544 || x >= 608) return 0;
        k   = (x - 544) / 16;
        off = (x - 544) % 16;
        if (off >= 12) return 0;
        if (k < 3 && (val >> (4 * (3 - k))) == 0) return 0;
        d = (val >> (4 * (3 - k))) % 16;
        if (d > 9) return 0;
        return int'(tb_font(d, ry / 4, off / 4));
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_px(int x, int y, int e);
        bus.hpos = 10'(x);
        bus.vpos = 10'(y);
        push(cyc + 2, 0, e, x, y);
        step();
    endtask

    task automatic px(int x, int y);
        drive_px(x, y, exp_pix(x, y));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) px(0, 0);
    endtask

    task automatic sweep();
        for (int y = 12; y < 63; y++)
            for (int x = 540; x < 612; x++) px(x, y);
        idle(3);
    endtask

    task automatic pulse(bit t, bit s);
        bus.game_tick  = t;
        bus.game_start = s;
        if (s) begin
            m_shown = '0;
            m_rec   = 1'b0;
        end else if (t) begin
            m_shown = bus.score;
        end
        if (t) m_blink = (m_blink + 1) % 32;
        drive_px(0, 0, 0);
        bus.game_tick  = 1'b0;
        bus.game_start = 1'b0;
        idle(3);
    endtask

    task automatic set_frozen(bit v);
        bit rec;
        bus.game_frozen = v;
        if (v && !m_frozen) begin
            rec = (bus.score > m_hi);
            if (rec) begin
                m_hi  = bus.score;
                m_rec = 1'b1;
            end
            push(cyc + 1, 2, int'(rec), 0, 0);
            push(cyc + 1, 1, int'(m_hi), 0, 0);
            push(cyc + 2, 2, 0, 0, 0);
        end
        m_frozen = v;
        drive_px(0, 0, 0);
        idle(3);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        bus.score       = '0;
        bus.game_tick   = 1'b0;
        bus.game_start  = 1'b0;
        bus.game_frozen = 1'b0;
        bus.hpos        = '0;
        bus.vpos        = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_now("reset_pixel_on", int'(bus.pixel_on), 0);
        check_now("reset_hiscore", int'(bus.hiscore), 0);
        check_now("reset_new_record", int'(bus.new_record), 0);
        rst_n = 1'b1;
        step();
        idle(2);

        // Score 0 renders a single "0" in both rows
        pulse(1'b1, 1'b0);
        sweep();
        drive_px(592, 16, 1);
        drive_px(603, 16, 1);
        drive_px(604, 16, 0);
        drive_px(591, 16, 0);
        drive_px(592, 40, 1);
        drive_px(603, 59, 1);
        drive_px(592, 36, 0);
        idle(3);

        // Snapshot timing
        bus.score = 16'h0123;
        idle(2);
        drive_px(592, 16, 1);
        drive_px(564, 16, 0);
        pulse(1'b1, 1'b0);
        drive_px(564, 16, 1);
        drive_px(560, 16, 0);
        drive_px(548, 16, 0);
        drive_px(592, 16, 1);
        idle(3);
        sweep();
        pulse(1'b1, 1'b1);
        drive_px(564, 16, 0);
        drive_px(592, 16, 1);
        idle(3);

        // High score on game over
        bus.score = 16'h0456;
        set_frozen(1'b1);
        check_now("hiscore_0456", int'(bus.hiscore), 16'h0456);
        set_frozen(1'b0);
        pulse(1'b0, 1'b1);
        set_frozen(1'b1);
        set_frozen(1'b0);
        pulse(1'b0, 1'b1);
        bus.score = 16'h0300;
        set_frozen(1'b1);
        check_now("hiscore_kept", int'(bus.hiscore), 16'h0456);
        set_frozen(1'b0);
        pulse(1'b0, 1'b1);

        // Blink after a record while frozen
        bus.score = 16'h0789;
        pulse(1'b1, 1'b0);
        set_frozen(1'b1);
        for (int t = 0; t < 32; t++) begin
            pulse(1'b1, 1'b0);
            for (int x = 588; x < 608; x++) begin
                px(x, 16);
                px(x, 40);
            end
            drive_px(592, 16, ((m_blink / 16) % 2 == 1) ? 0 : 1);
            idle(3);
        end
        pulse(1'b0, 1'b1);
        sweep();
        set_frozen(1'b0);

        // Full digits and cell boundaries
        bus.score = 16'h9999;
        pulse(1'b1, 1'b0);
        sweep();
        drive_px(556, 16, 0);
        drive_px(555, 35, 1);
        drive_px(544, 16, 1);
        idle(3);

        // Async reset mid-line
        for (int i = 0; i < 4; i++) drive_px(555, 16, 1);
        drain();
        check_now("pre_reset_pixel_on", int'(bus.pixel_on), 1);
        check_now("pre_reset_hiscore", int'(bus.hiscore), 16'h0789);
        #1;
        rst_n = 1'b0;
        #1;
        check_now("async_pixel_on", int'(bus.pixel_on), 0);
        check_now("async_hiscore", int'(bus.hiscore), 0);
        check_now("async_new_record", int'(bus.new_record), 0);
        m_shown = '0;
        m_hi    = '0;
        m_rec   = 1'b0;
        m_blink = 0;
        step();
        rst_n = 1'b1;
        step();
        idle(2);
        bus.score = 16'h0042;
        pulse(1'b1, 1'b0);
        sweep();

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/score_display.md
# score_display

Downstream consumer of the 16-bit packed-BCD game score. It holds a per-frame snapshot of the live score and a session high score, and renders both as scaled 3x5-font digits into the VGA pixel stream. `pixel_on` drives the score colour in the top-level pixel mux. A new high score makes both rows blink while the game is frozen.

## Interface
- `X0`, 544: left pixel column of the leftmost digit (both rows).
- `Y0`, 16: top pixel row of the score row; the high-score row starts at `Y0+24`.
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `score`  in  16: live score, packed BCD, thousands digit in [15:12]; each nibble 0..9.
- `game_tick`  in  1: one-cycle end-of-frame pulse, 60 Hz.
- `game_start`  in  1: one-cycle new-game pulse.
- `game_frozen`  in  1: level, high while the game is over/frozen.
- `hpos`, `vpos`  in  10 each: current beam pixel coordinates.
- `pixel_on`  out  1: registered; high when the beam pixel (2 cycles earlier) is a lit digit pixel.
- `hiscore`  out  16: registered packed-BCD high score.
- `new_record`  out  1: registered one-cycle pulse when `hiscore` is updated.

## Operation
- **Score snapshot `shown`.**
  - Loads `score` on `game_tick`.
  - Clears to 0 on `game_start`; `game_start` beats a simultaneous `game_tick`.
  - Holds at all other times, so the display never tears mid-frame.
- **Frozen edge detect.** `frz_d` is `game_frozen` delayed one cycle; `go_edge = game_frozen & ~frz_d`.
- **High score update.**
  - On `go_edge` with `score > hiscore`, load `hiscore <= score`, pulse `new_record`, and set `rec_flag`.
  - The comparison is an unsigned 16-bit compare, which is exact for valid packed BCD.
  - Equal scores do not count as a record.
- **`rec_flag` clear.** Cleared on `game_start`. `game_start` beats a simultaneous `go_edge`: no compare and no pulse that cycle.
- **`hiscore` persistence.** Cleared only by `rst_n`; `game_start` does not clear it.
- **Blink counter.** 5-bit `blink`, incremented on every `game_tick` with natural wrap 31→0. Blanking is active while `game_frozen & rec_flag & blink[4]`.
- **Geometry.**
  - Each row has 4 digit slots. Slot k=0..3 (k=0 is the thousands digit) spans x in [X0+16k, X0+16k+12).
  - Score row spans y in [Y0, Y0+20); high-score row spans y in [Y0+24, Y0+44).
  - Each font cell is 4x4 px: `col = (x-slotbase)>>2` (0..2), `row = (y-rowbase)>>2` (0..4).
  - The 4-px gap between slots is always dark.
- **Font.** Rows top→bottom, bit2 = left column:
  - 0: 7,5,5,5,7 · 1: 2,6,2,2,7 · 2: 7,1,7,4,7 · 3: 7,1,7,1,7 · 4: 5,5,7,1,1
  - 5: 7,4,7,1,7 · 6: 7,4,7,5,7 · 7: 7,1,1,1,1 · 8: 7,5,7,5,7 · 9: 7,5,7,1,7
  - Nibbles 10..15 render blank.
- **Leading-zero blanking, per row.** Digit k<3 is blank if it and all digits left of it are 0. The units digit is always drawn, so a value of 0 renders as a single "0".
- **Pipeline.**
  - Stage 1 registers: in-box flag, row select, slot index, cell col/row.
  - Stage 2: digit select, font lookup, blanking → `pixel_on`.

## Timing
- **Reset values.** `shown`, `hiscore`, `blink`, `rec_flag`, `frz_d`, pipeline registers, `pixel_on` and `new_record` all 0.
- **`pixel_on` latency.** Exactly 2 clocks after `hpos`/`vpos`; the top level delays its own coordinates to match.
- **Snapshot / font-lookup timing.** A `shown` update from `game_tick` at cycle t is used by the font lookup from cycle t+1. Stage 2 samples `shown` and `hiscore` directly, not pipelined copies.
- **Record timing.** `new_record` and the `hiscore` update occur 1 clock after the cycle `go_edge` is first seen, i.e. 1 clock after `game_frozen` rises.
- **Reset mid-operation.** An asynchronous `rst_n` assert clears everything immediately, and `pixel_on` drops at once. After release, output is valid from the second clock.

## Test plan
- **Reset and pipeline latency.** Reset, hold `score`=0x0000, pulse `game_tick`, sweep a frame. `pixel_on` lights only the "0" glyph at x 592..603, y 16..35 and at y 40..59. All lit pixels appear 2 cycles after their coordinates.
- **Snapshot timing.** `score`=0x0123, no tick: display still shows 0. After one `game_tick`: score row shows "123" (slot 0 blank). Pulsing `game_start` and `game_tick` in the same cycle leaves it showing 0.
- **High score on game over.** Score 0x0456 with `game_frozen` rising: `new_record` pulses once a cycle later and `hiscore`=0x0456. Next game ends at 0x0456: no pulse. A game ending at 0x0300 leaves `hiscore` unchanged.
- **Blink.** After a record while frozen, count 32 `game_tick`s. `pixel_on` is fully dark for ticks with `blink[4]`=1 and normal otherwise. A `game_start` stops blinking, and the next frame renders normally.
- **Full digits and cell boundaries.** `score`=0x9999 with a tick: all four slots render "9". Pixel (X0+12, Y0) is dark; (X0+11, Y0+19) is lit (bottom-right cell of "9").
- **Async reset mid-frame.** With digits lit, assert `rst_n` low mid-line: `pixel_on`, `hiscore` and `new_record` go 0 without waiting for `clk`.
